// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the loader FSM encoding and byte/word sizing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

    // A length byte of zero requests a full 256-word image.
    localparam int LEN_ZERO_WORDS = 256;

    function automatic int bytes_per_word(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: byte source side (drives rx_data/rx_valid, sees the rest).
// slave : loader side (drives rx_ready and the mem_* write port).
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a byte counter.
// Ports: clk100, rst, i_clear, i_shift, i_byte -> o_word, o_full.
// o_word is the word including the byte being shifted this cycle;
// o_full flags that this shift completes a word.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_full
);
    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;

    assign o_word = (r_shift << 8) | DATA_W'(i_byte);
    assign o_full = i_shift && (r_cnt == CNT_W'(BPW - 1));

    always_ff @(posedge clk100) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= o_word;
            r_cnt   <= o_full ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory,
// holding the CPU until the load completes.
// Ports: clk100, rst (sync, active-high), i_start, bus (rx stream in,
// mem write out), o_cpu_hold, o_busy, o_done; o_csum_err when built
// with IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic           clk100,
    input  logic           rst,
    input  logic           i_start,
    imem_loader_if.slave   bus,
    output logic           o_cpu_hold,
    output logic           o_busy,
    output logic           o_done
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic           o_csum_err
`endif
);
    localparam logic [ADDR_W:0]   LEN_ZERO = (ADDR_W+1)'(LEN_ZERO_WORDS);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_word;
    logic              w_acc;
    logic              w_start;
    logic              w_full;
    logic              w_last;

    assign w_acc   = bus.rx_valid & bus.rx_ready;
    assign w_start = (r_state == S_IDLE) & i_start;
    assign w_last  = (r_idx == r_len - 1'b1);

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign o_cpu_hold    = o_busy;

    imem_loader_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk100  (clk100),
        .rst     (rst),
        .i_clear (w_start),
        .i_shift (w_acc && (r_state == S_DATA)),
        .i_byte  (bus.rx_data),
        .o_word  (w_word),
        .o_full  (w_full)
    );

    always_ff @(posedge clk100) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus.rx_ready = 1'b0;
        bus.mem_we   = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_LEN;
            end
            S_LEN: begin
                bus.rx_ready = 1'b1;
                if (w_acc) w_next = S_DATA;
            end
            S_DATA: begin
                bus.rx_ready = 1'b1;
                if (w_full) w_next = S_WRITE;
            end
            S_WRITE: begin
                bus.mem_we = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_next = w_last ? S_CSUM : S_DATA;
`else
                w_next = w_last ? S_DONE : S_DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                bus.rx_ready = 1'b1;
                if (w_acc) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Address and data are captured on the completing byte so they
    // are stable through the write cycle and hold afterwards.
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_start) r_idx <= '0;
            if (r_state == S_LEN && w_acc) begin
                r_len <= (bus.rx_data == 8'd0) ? LEN_ZERO
                                               : (ADDR_W+1)'(bus.rx_data);
            end
            if (w_full) begin
                r_mem_addr  <= BASE + r_idx[ADDR_W-1:0];
                r_mem_wdata <= w_word;
            end
            if (r_state == S_WRITE && !w_last) r_idx <= r_idx + 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_err;

    assign o_csum_err = r_csum_err;

    // Error flag is updated on the checksum byte so it is valid
    // in the same cycle as the done pulse.
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_csum     <= '0;
            r_csum_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_csum     <= '0;
                r_csum_err <= 1'b0;
            end
            if (r_state == S_DATA && w_acc) r_csum <= r_csum ^ bus.rx_data;
            if (r_state == S_CSUM && w_acc) r_csum_err <= (bus.rx_data != r_csum);
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0x00 and
// 0xFE), randomized byte streams checked against a write-list model.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;
    typedef wr_t wq_t[$];

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       hold0, busy0, done0;
    logic       hold1, busy1, done1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic       cerr0, cerr1;
`endif

    int tests = 0;
    int fails = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    int rdyerr = 0;
    wq_t obs0;
    wq_t obs1;

    imem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
    imem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

    assign bus0.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid;
    assign bus1.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;

    imem_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0)) dut0 (
        .clk100     (clk100),
        .rst        (rst),
        .i_start    (start0),
        .bus        (bus0),
        .o_cpu_hold (hold0),
        .o_busy     (busy0),
        .o_done     (done0)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .o_csum_err (cerr0)
`endif
    );

    imem_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(254)) dut1 (
        .clk100     (clk100),
        .rst        (rst),
        .i_start    (start1),
        .bus        (bus1),
        .o_cpu_hold (hold1),
        .o_busy     (busy1),
        .o_done     (done1)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .o_csum_err (cerr1)
`endif
    );

    always @(negedge clk100) begin
        if (bus0.mem_we) obs0.push_back({bus0.mem_addr, bus0.mem_wdata});
        if (bus1.mem_we) obs1.push_back({bus1.mem_addr, bus1.mem_wdata});
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
        if (bus0.mem_we && bus0.rx_ready) rdyerr++;
        if (bus1.mem_we && bus1.rx_ready) rdyerr++;
        if (busy0 && !done0 && !bus0.mem_we && !bus0.rx_ready) rdyerr++;
        if (busy1 && !done1 && !bus1.mem_we && !bus1.rx_ready) rdyerr++;
    end

    function automatic logic rdy(input int sel);
        return sel != 0 ? bus1.rx_ready : bus0.rx_ready;
    endfunction
    function automatic logic dn(input int sel);
        return sel != 0 ? done1 : done0;
    endfunction
    function automatic logic hld(input int sel);
        return sel != 0 ? (hold1 | busy1) : (hold0 | busy0);
    endfunction
    function automatic wq_t get_obs(input int sel);
        return sel != 0 ? obs1 : obs0;
    endfunction
    function automatic int get_done(input int sel);
        return sel != 0 ? done1_cnt : done0_cnt;
    endfunction

    // Stream = length byte, data bytes, and (checksum build) XOR byte.
    function automatic bq_t mk_stream(input logic [7:0] len, input bq_t d);
        bq_t s;
        logic [7:0] x;
        x = 8'h00;
        s.push_back(len);
        foreach (d[i]) begin
            s.push_back(d[i]);
            x ^= d[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
        return s;
    endfunction

    // Expected memory writes: word w = bytes 4w..4w+3 big-endian
    // at (base + w) mod 256; length 0 means 256 words.
    function automatic wq_t model(input logic [7:0] len, input bq_t d,
                                  input logic [7:0] base);
        wq_t e;
        wr_t t;
        int n;
        n = (len == 8'd0) ? 256 : int'(len);
        for (int w = 0; w < n; w++) begin
            t.a = 8'(int'(base) + w);
            t.d = {d[4*w], d[4*w+1], d[4*w+2], d[4*w+3]};
            e.push_back(t);
        end
        return e;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t d;
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        return d;
    endfunction

    task automatic pulse_start(input int sel);
        @(negedge clk100);
        obs0.delete();
        obs1.delete();
        done0_cnt = 0;
        done1_cnt = 0;
        if (sel != 0) start1 = 1'b1;
        else          start0 = 1'b1;
        @(negedge clk100);
        start0 = 1'b0;
        start1 = 1'b0;
        tests++;
        if (hld(sel) !== 1'b1) begin
            fails++;
            $display("FAIL hold_after_start got %b want 1", hld(sel));
        end
    endtask

    // gap: 0 full rate, 1 valid every other cycle, 2 random.
    task automatic drive(input int sel, input bq_t s, input int gap,
                         input int limit);
        int i;
        int cyc;
        bit ph;
        logic v;
        i = 0;
        cyc = 0;
        ph = 1'b0;
        while (i < limit && i < s.size() && cyc < 20000) begin
            @(negedge clk100);
            cyc++;
            case (gap)
                0:       v = 1'b1;
                1:       begin v = ph; ph = ~ph; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            rx_valid = v;
            rx_data  = v ? s[i] : 8'($urandom);
            if (v && rdy(sel)) i++;
        end
        @(negedge clk100);
        rx_valid = 1'b0;
        if (cyc >= 20000) begin
            tests++;
            fails++;
            $display("FAIL drive_timeout got %0d bytes want %0d", i, limit);
        end
    endtask

    task automatic wait_done(input int sel);
        int c;
        c = 0;
        while (!dn(sel) && c < 3000) begin
            @(negedge clk100);
            c++;
        end
        if (c >= 3000) begin
            tests++;
            fails++;
            $display("FAIL done_timeout got no done want done");
        end
        @(negedge clk100);
    endtask

    task automatic load(input int sel, input bq_t s, input int gap);
        pulse_start(sel);
        drive(sel, s, gap, s.size());
        wait_done(sel);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start0 = 1'b1;
        repeat (3) @(negedge clk100);
        start0 = 1'b0;
        tests++;
        if ({hold0, busy0, done0, bus0.mem_we, bus0.rx_ready} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl0 got %b want 00000",
                     {hold0, busy0, done0, bus0.mem_we, bus0.rx_ready});
        end
        tests++;
        if ({bus0.mem_addr, bus0.mem_wdata} !== 40'h0) begin
            fails++;
            $display("FAIL reset_bus0 got %h/%h want 0/0",
                     bus0.mem_addr, bus0.mem_wdata);
        end
        tests++;
        if ({hold1, busy1, done1, bus1.mem_we, bus1.rx_ready} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl1 got %b want 00000",
                     {hold1, busy1, done1, bus1.mem_we, bus1.rx_ready});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        tests++;
        if ({cerr0, cerr1} !== 2'b00) begin
            fails++;
            $display("FAIL reset_cerr got %b want 00", {cerr0, cerr1});
        end
`endif
        rst = 1'b0;
        @(negedge clk100);
        tests++;
        if (bus0.rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_rx_ready got %b want 0", bus0.rx_ready);
        end
    endtask

    task automatic test_load(input string nm, input int sel,
                             input logic [7:0] len, input bq_t d,
                             input int gap);
        wq_t e;
        wq_t o;
        e = model(len, d, sel != 0 ? 8'hFE : 8'h00);
        load(sel, mk_stream(len, d), gap);
        o = get_obs(sel);
        tests++;
        if (o.size() != e.size()) begin
            fails++;
            $display("FAIL %s_nwrites got %0d want %0d", nm, o.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < o.size(); i++) begin
            tests++;
            if (o[i] !== e[i]) begin
                fails++;
                $display("FAIL %s_w%0d got %h:%h want %h:%h", nm, i,
                         o[i].a, o[i].d, e[i].a, e[i].d);
            end
        end
        tests++;
        if (get_done(sel) != 1) begin
            fails++;
            $display("FAIL %s_done got %0d want 1", nm, get_done(sel));
        end
        tests++;
        if (hld(sel) !== 1'b0) begin
            fails++;
            $display("FAIL %s_release got %b want 0", nm, hld(sel));
        end
    endtask

    task automatic test_basic;
        bq_t d;
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        test_load("basic", 0, 8'd2, d, 0);
    endtask

    task automatic test_stall;
        bq_t d;
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        test_load("stall", 0, 8'd2, d, 1);
    endtask

    task automatic test_random;
        int n;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 7);
            test_load("rand", k % 2, 8'(n), rand_bytes(4 * n),
                      $urandom_range(0, 2));
        end
    endtask

    task automatic test_full_256;
        test_load("full256", 0, 8'd0, rand_bytes(1024), 0);
    endtask

    task automatic test_wrap;
        test_load("wrap", 1, 8'd3, rand_bytes(12), 2);
    endtask

    task automatic test_reset_mid;
        bq_t d;
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_start(0);
        drive(0, mk_stream(8'd2, d), 0, 7);
        rst = 1'b1;
        @(negedge clk100);
        rst = 1'b0;
        tests++;
        if ({hold0, busy0, done0, bus0.mem_we, bus0.rx_ready} !== 5'b0) begin
            fails++;
            $display("FAIL rstmid_ctrl got %b want 00000",
                     {hold0, busy0, done0, bus0.mem_we, bus0.rx_ready});
        end
        tests++;
        if ({bus0.mem_addr, bus0.mem_wdata} !== 40'h0) begin
            fails++;
            $display("FAIL rstmid_bus got %h/%h want 0/0",
                     bus0.mem_addr, bus0.mem_wdata);
        end
        repeat (6) @(negedge clk100);
        tests++;
        if (obs0.size() != 1 || obs0[0] !== {8'h00, 32'h11223344}) begin
            fails++;
            $display("FAIL rstmid_writes got %0d writes want 1 of 00:11223344",
                     obs0.size());
        end
        tests++;
        if (done0_cnt != 0) begin
            fails++;
            $display("FAIL rstmid_done got %0d want 0", done0_cnt);
        end
        test_load("after_rst", 0, 8'd2, d, 0);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_csum;
        bq_t d;
        bq_t s;
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        s = mk_stream(8'd1, d);
        load(0, s, 0);
        tests++;
        if (cerr0 !== 1'b0 || done0_cnt != 1) begin
            fails++;
            $display("FAIL csum_good got err=%b done=%0d want 0/1",
                     cerr0, done0_cnt);
        end
        s[s.size()-1] = 8'h05;
        load(0, s, 2);
        tests++;
        if (cerr0 !== 1'b1 || done0_cnt != 1) begin
            fails++;
            $display("FAIL csum_bad got err=%b done=%0d want 1/1",
                     cerr0, done0_cnt);
        end
        pulse_start(0);
        tests++;
        if (cerr0 !== 1'b0) begin
            fails++;
            $display("FAIL csum_clear got %b want 0", cerr0);
        end
        drive(0, mk_stream(8'd1, d), 0, 6);
        wait_done(0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_full_256();
        test_wrap();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_csum();
`endif
        tests++;
        if (rdyerr != 0) begin
            fails++;
            $display("FAIL rx_ready_vs_write got %0d bad cycles want 0", rdyerr);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
